// File: rtl/fifo_ram_pkg.sv
// Shared sizing helpers for the handshake FIFOs (fifo_ram, fifo_register and friends).
package fifo_ram_pkg;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned bits;
        bits = 0;
        while ((64'd1 << bits) < 64'(value)) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

    // Occupancy must represent 0..depth inclusive.
    function automatic int unsigned count_bits(input int unsigned depth);
        return clog2(depth + 1);
    endfunction

    function automatic int unsigned ptr_bits(input int unsigned depth);
        return (depth > 1) ? clog2(depth) : 1;
    endfunction

    localparam int unsigned FIFO_DEFAULT_WIDTH     = 32;
    localparam int unsigned FIFO_DEFAULT_BUFFERING = 16;
    localparam int unsigned FIFO_DEFAULT_COUNT_W   = count_bits(FIFO_DEFAULT_BUFFERING);
    localparam int unsigned FIFO_DEFAULT_PTR_W     = ptr_bits(FIFO_DEFAULT_BUFFERING);

endpackage

// File: rtl/fifo_ram_mem.sv
// Simple dual-port RAM: one synchronous write port, one registered read port (read-old-data).
module fifo_ram_mem
    import fifo_ram_pkg::*;
#(
    parameter int unsigned Width = FIFO_DEFAULT_WIDTH,
    parameter int unsigned Depth = FIFO_DEFAULT_BUFFERING,
    parameter int unsigned AddrW = ptr_bits(Depth)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AddrW-1:0] wr_addr,
    input  logic [Width-1:0] wr_data,
    input  logic [AddrW-1:0] rd_addr,
    output logic [Width-1:0] rd_data
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_ram.sv
// RAM-backed first-word-fall-through FIFO with valid/ready on both sides.
// Define FIFO_RAM_ASSERT_EN to compile in simulation-only protocol checks.
module fifo_ram
    import fifo_ram_pkg::*;
#(
    parameter int unsigned Width     = FIFO_DEFAULT_WIDTH,
    parameter int unsigned Buffering = FIFO_DEFAULT_BUFFERING
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [Width-1:0] InData,
    input  logic             InValid,
    output logic             InAccept,
    output logic [Width-1:0] OutData,
    output logic             OutSend,
    input  logic             OutReady
);

    localparam int unsigned PtrW   = ptr_bits(Buffering);
    localparam int unsigned CountW = count_bits(Buffering);
    localparam logic [PtrW-1:0]   PtrLast   = PtrW'(Buffering - 1);
    localparam logic [CountW-1:0] CountFull = CountW'(Buffering);

    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CountW-1:0] count_q, count_d;
    logic              out_valid_q, out_valid_d;
    logic              bypass_sel_q, bypass_sel_d;
    logic [Width-1:0]  bypass_data_q, bypass_data_d;
    logic [Width-1:0]  ram_rd_data;
    logic              write, read;

    assign InAccept = !Reset && (count_q < CountFull);
    assign write    = InValid && InAccept;
    assign read     = out_valid_q && OutReady;

    // The RAM always reads the next head; the bypass covers a head written on the same edge.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        bypass_data_d = bypass_data_q;
        bypass_sel_d  = 1'b0;

        if (write) begin
            wr_ptr_d      = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
            bypass_data_d = InData;
            bypass_sel_d  = (count_q == CountW'(read));
        end
        if (read) begin
            rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
        end

        if (write && !read) begin
            count_d = count_q + CountW'(1);
        end else if (!write && read) begin
            count_d = count_q - CountW'(1);
        end

        out_valid_d = (count_d != '0);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            out_valid_q  <= 1'b0;
            bypass_sel_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            out_valid_q  <= out_valid_d;
            bypass_sel_q <= bypass_sel_d;
        end
    end

    always_ff @(posedge Clock) begin
        bypass_data_q <= bypass_data_d;
    end

    fifo_ram_mem #(
        .Width (Width),
        .Depth (Buffering),
        .AddrW (PtrW)
    ) u_mem (
        .clk     (Clock),
        .wr_en   (write),
        .wr_addr (wr_ptr_q),
        .wr_data (InData),
        .rd_addr (rd_ptr_d),
        .rd_data (ram_rd_data)
    );

    assign OutSend = out_valid_q;
    assign OutData = bypass_sel_q ? bypass_data_q : ram_rd_data;

`ifdef FIFO_RAM_ASSERT_EN
    logic             chk_in_stall_q;
    logic             chk_out_stall_q;
    logic [Width-1:0] chk_in_data_q;
    logic [Width-1:0] chk_out_data_q;

    always @(posedge Clock) begin
        if (!Reset) begin
            if (chk_in_stall_q && InValid && (InData != chk_in_data_q)) begin
                $display("fifo_ram: InData changed while InValid held without InAccept");
                $finish;
            end
            if (count_q > CountFull) begin
                $display("fifo_ram: occupancy %0d exceeds capacity %0d", count_q, Buffering);
                $finish;
            end
            if (chk_out_stall_q && (OutData != chk_out_data_q)) begin
                $display("fifo_ram: OutData changed while stalled");
                $finish;
            end
        end
        chk_in_stall_q  <= !Reset && InValid && !InAccept;
        chk_out_stall_q <= !Reset && OutSend && !OutReady;
        chk_in_data_q   <= InData;
        chk_out_data_q  <= OutData;
    end
`else
    // No checking logic in this build.
`endif

endmodule

// File: tb/tb_fifo_ram.sv
// Self-checking bench for fifo_ram (Width=8, Buffering=4): vector table plus scoreboard sequences.
module tb_fifo_ram;

    localparam int unsigned W = 8;
    localparam int unsigned D = 4;

    logic         Clock;
    logic         Reset;
    logic [W-1:0] InData;
    logic         InValid;
    logic         InAccept;
    logic [W-1:0] OutData;
    logic         OutSend;
    logic         OutReady;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] sb_q[$];

    typedef struct {
        logic         in_valid;
        logic [W-1:0] in_data;
        logic         out_ready;
        logic         exp_accept;
        logic         exp_send;
        logic         chk_data;
        logic [W-1:0] exp_data;
    } vec_t;

    vec_t vecs[13];

    fifo_ram #(
        .Width     (W),
        .Buffering (D)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .InData   (InData),
        .InValid  (InValid),
        .InAccept (InAccept),
        .OutData  (OutData),
        .OutSend  (OutSend),
        .OutReady (OutReady)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Score the transfers that the coming rising edge will perform, then advance to the next falling edge.
    task automatic cycle();
        logic [W-1:0] exp;
        if (OutSend && OutReady) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: read %0h with nothing queued", OutData);
            end else begin
                exp = sb_q.pop_front();
                check("sb_order", 32'(OutData), 32'(exp));
            end
        end
        if (InValid && InAccept) sb_q.push_back(InData);
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic drain(input string name);
        InValid  = 1'b0;
        OutReady = 1'b1;
        for (int n = 0; n < 16 && OutSend; n++) cycle();
        check({name, "_send_low"}, 32'(OutSend), 32'd0);
        check({name, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
        OutReady = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic stalled;

        vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11};
        vecs[2]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11};
        vecs[3]  = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11};
        vecs[4]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h44};
        vecs[9]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA5};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};

        Reset    = 1'b1;
        InValid  = 1'b0;
        InData   = '0;
        OutReady = 1'b0;
        repeat (2) @(negedge Clock);
        check("rst_send", 32'(OutSend), 32'd0);
        check("rst_accept", 32'(InAccept), 32'd0);
        Reset = 1'b0;
        #1;
        check("rel_accept", 32'(InAccept), 32'd1);

        // Fill, stalled fifth offer, drain, then empty-FIFO latency.
        for (int i = 0; i < 13; i++) begin
            InValid  = vecs[i].in_valid;
            InData   = vecs[i].in_data;
            OutReady = vecs[i].out_ready;
            check($sformatf("vec%0d_accept", i), 32'(InAccept), 32'(vecs[i].exp_accept));
            check($sformatf("vec%0d_send", i), 32'(OutSend), 32'(vecs[i].exp_send));
            if (vecs[i].chk_data) begin
                check($sformatf("vec%0d_data", i), 32'(OutData), 32'(vecs[i].exp_data));
            end
            cycle();
        end
        check("table_sb_empty", 32'(sb_q.size()), 32'd0);

        // Streaming: one write and one read every cycle, pointers wrapping repeatedly.
        for (int i = 0; i < 20; i++) begin
            InValid  = 1'b1;
            InData   = 8'(i);
            OutReady = 1'b1;
            if (i > 0) check("stream_send", 32'(OutSend), 32'd1);
            check("stream_accept", 32'(InAccept), 32'd1);
            cycle();
        end
        drain("stream");

        // Random stall: occupancy model from the scoreboard depth.
        stalled = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            InValid  = 1'($urandom_range(0, 1));
            OutReady = 1'($urandom_range(0, 1));
            if (!stalled) InData = 8'($urandom);
            check("rnd_accept", 32'(InAccept), 32'(sb_q.size() < D));
            check("rnd_send", 32'(OutSend), 32'(sb_q.size() != 0));
            stalled = InValid && !InAccept;
            cycle();
        end
        drain("rnd");

        // Full FIFO read: no accept on the read cycle, accept on the next.
        for (int i = 0; i < 4; i++) begin
            InValid = 1'b1;
            InData  = 8'(8'hC0 + i);
            cycle();
        end
        OutReady = 1'b1;
        InData   = 8'hCF;
        check("full_read_accept", 32'(InAccept), 32'd0);
        cycle();
        check("after_full_read_accept", 32'(InAccept), 32'd1);
        check("after_full_read_data", 32'(OutData), 32'hC1);
        cycle();
        drain("full");

        // Reset with three words queued discards them immediately.
        for (int i = 0; i < 3; i++) begin
            InValid = 1'b1;
            InData  = 8'(8'h31 + i);
            cycle();
        end
        InValid = 1'b0;
        check("pre_rst_send", 32'(OutSend), 32'd1);
        Reset = 1'b1;
        #1;
        check("mid_rst_send", 32'(OutSend), 32'd0);
        check("mid_rst_accept", 32'(InAccept), 32'd0);
        sb_q.delete();
        @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        check("post_rst_accept", 32'(InAccept), 32'd1);
        check("post_rst_send", 32'(OutSend), 32'd0);
        InValid = 1'b1;
        InData  = 8'h77;
        cycle();
        InValid = 1'b0;
        check("post_rst_head_send", 32'(OutSend), 32'd1);
        check("post_rst_head_data", 32'(OutData), 32'h77);
        drain("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
